mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified memory port between the instruction requester (fetch stage, imem) and the data requester (load/store path, dmem).
- Accepts at most one request per requester and queues the loser in a one-entry pending slot per requester.
- Issues one downstream transaction at a time and routes each response back to its owner.
- Sits between the fetch/memory stages and the single memory or cache port.

Parameters:
- RR_MODE, 0, 0 = fixed data-over-instruction priority; 1 = round-robin between the two requesters (ties go to the requester not most recently granted).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state)
- imem_in  in  mem_in_type  instruction request: mem_valid, mem_fence, mem_spec, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]
- imem_out  out  mem_out_type  instruction response: mem_rdata[31:0], mem_ready
- dmem_in  in  mem_in_type  data request, same fields
- dmem_out  out  mem_out_type  data response
- mem_in  out  mem_in_type  downstream request to the shared memory
- mem_out  in  mem_out_type  downstream response
- grant_instr  out  1  registered; 1 while the outstanding transaction belongs to imem

Behaviour:
- Protocol:
  - mem_valid is a one-cycle request pulse; all request fields are valid only in that cycle.
  - A response is mem_ready=1 for one cycle, one or more cycles after the request.
  - Each requester has at most one request outstanding or pending; it may pulse a new request in the same cycle its ready returns.
- Per-requester pending slot: pend_v plus captured fields. All state is cleared to 0 on reset.
- States:
  - idle: nothing outstanding.
  - busy_i: instruction transaction outstanding.
  - busy_d: data transaction outstanding.
- Candidates in a cycle:
  - A requester's candidate is its live request (mem_valid=1 this cycle), otherwise its pending slot.
  - The live request always supersedes that requester's pending slot.
- Issue condition: state==idle, or state is busy and mem_out.mem_ready==1 (back-to-back issue in the completion cycle).
- Issue action:
  - Select the winner by priority: RR_MODE=0 picks dmem; RR_MODE=1 picks the requester not last granted.
  - Drive mem_in combinationally with the winner's fields and mem_valid=1: zero added latency.
  - Go to busy_i or busy_d.
  - The losing candidate, if live, is written into its pending slot.
  - The winner's slot is cleared.
- No issue possible (busy, no ready): live requests are written into their pending slots; mem_in.mem_valid=0.
- mem_in when not issuing: all fields 0.
- Response routing:
  - In busy_i, mem_out.mem_ready goes to imem_out.mem_ready. In busy_d, it goes to dmem_out.mem_ready.
  - The non-owner's ready is 0.
  - mem_rdata is forwarded to the owner; the non-owner's rdata is 0.
  - On completion with nothing to issue, go to idle.
- Speculation and fences:
  - imem mem_spec and mem_fence are forwarded unchanged with the instruction request they accompany.
  - A live spec request overwrites any pending instruction request; the stale request is never issued.
  - An already outstanding transaction is never cancelled; its response is delivered.
- mem_ready while idle (stray, e.g. after reset mid-transaction): ignored, not forwarded.
- Outputs during and after reset: imem_out, dmem_out and mem_in fields are all 0, grant_instr=0, state idle.
- Reset mid-transaction drops the outstanding ownership and both pending slots.
- Starvation:
  - RR_MODE=1 bounds the wait to one transaction.
  - RR_MODE=0 relies on dmem issuing at most one request per instruction.

Test Plan:
- Idle, imem pulse addr=0x100, memory ready 2 cycles later with rdata=0xDEADBEEF -> mem_in valid in the same cycle as the pulse; imem_out ready=1, rdata=0xDEADBEEF; dmem_out ready=0; grant_instr=1 then 0.
- Same-cycle imem 0x200 and dmem 0x8000 (RR_MODE=0) -> dmem issued first. The ready for 0x8000 goes to dmem, and 0x200 is issued in that same ready cycle. A second ready goes to imem.
- dmem outstanding, imem pulses 0x300, then a spec pulse to 0x400 before dmem completes -> only 0x400 is issued downstream (mem_spec=1); 0x300 is never issued.
- RR_MODE=1, both requesters re-requesting continuously for 6 transactions -> grants alternate d,i,d,i,d,i.
- reset=0 asserted while busy_d, then a stray mem_ready after release -> all outputs 0, nothing routed, next imem request issues normally.
- Back-to-back: imem issues its next request in the same cycle as its ready, dmem idle -> issued the same cycle, no bubble; mem_wstrb=0 and mem_instr=1 propagated.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (imem) and load/store (dmem).
// Latency: a winning request reaches mem_in in the same cycle it is presented (combinational issue).
// Backpressure: one transaction in flight; a requester that cannot issue waits in its one-entry pending slot.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   imem_in/imem_out  instruction request pulse / routed response
//   dmem_in/dmem_out  data request pulse / routed response
//   mem_in/mem_out    shared downstream request / response
//   grant_instr       registered, 1 while the outstanding transaction belongs to imem
//   RR_MODE           0: dmem always wins a tie; 1: tie goes to the requester not granted last

package mem_arbiter_pkg;
  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit RR_MODE = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out,
  output logic        grant_instr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t     state, state_nxt;
  // Pending slots reuse mem_valid as the slot-occupied flag.
  mem_in_type pend_i, pend_i_nxt;
  mem_in_type pend_d, pend_d_nxt;
  logic       last_d, last_d_nxt;   // 1 when the most recent grant went to dmem
  mem_in_type cand_i, cand_d;
  logic       can_issue;
  logic       pick_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pend_i      <= '0;
      pend_d      <= '0;
      last_d      <= 1'b0;
      grant_instr <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend_i      <= pend_i_nxt;
      pend_d      <= pend_d_nxt;
      last_d      <= last_d_nxt;
      grant_instr <= (state_nxt == BUSY_I);
    end
  end

  always_comb begin
    state_nxt  = state;
    pend_i_nxt = pend_i;
    pend_d_nxt = pend_d;
    last_d_nxt = last_d;
    mem_in     = '0;
    imem_out   = '0;
    dmem_out   = '0;

    // A live pulse always supersedes the same requester's pending slot, which is
    // how a new speculative fetch discards a stale queued fetch.
    cand_i = imem_in.mem_valid ? imem_in : pend_i;
    cand_d = dmem_in.mem_valid ? dmem_in : pend_d;

    // Gated by reset so that nothing leaks to mem_in while reset is held.
    can_issue = reset && ((state == IDLE) || mem_out.mem_ready);

    // dmem wins unless round-robin says imem's turn (dmem was granted last).
    pick_d = cand_d.mem_valid &&
             (!cand_i.mem_valid || (RR_MODE == 1'b0) || !last_d);

    // Responses only route to the current owner; a ready seen in IDLE is dropped.
    case (state)
      BUSY_I:  imem_out = mem_out;
      BUSY_D:  dmem_out = mem_out;
      default: ;
    endcase

    if (can_issue) begin
      if (state != IDLE) begin
        state_nxt = IDLE;
      end
      if (cand_i.mem_valid || cand_d.mem_valid) begin
        if (pick_d) begin
          mem_in     = cand_d;
          state_nxt  = BUSY_D;
          last_d_nxt = 1'b1;
          pend_d_nxt = '0;
          if (imem_in.mem_valid) begin
            pend_i_nxt = imem_in;
          end
        end else begin
          mem_in     = cand_i;
          state_nxt  = BUSY_I;
          last_d_nxt = 1'b0;
          pend_i_nxt = '0;
          if (dmem_in.mem_valid) begin
            pend_d_nxt = dmem_in;
          end
        end
        mem_in.mem_valid = 1'b1;
      end
    end else begin
      if (imem_in.mem_valid) begin
        pend_i_nxt = imem_in;
      end
      if (dmem_in.mem_valid) begin
        pend_d_nxt = dmem_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Latency: checks are sampled just after the falling edge, inputs change just after the rising edge.
// Backpressure: memory readiness is driven by the bench, randomly in the soak phase.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  mem_in_type  imem_in, dmem_in;
  mem_out_type mem_out;
  mem_in_type  mi0, mi1;
  mem_out_type io0, do0, io1, do1;
  logic        g0, g1;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt300   = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.RR_MODE(1'b0)) dut0 (
    .clock(clock), .reset(reset), .imem_in(imem_in), .imem_out(io0),
    .dmem_in(dmem_in), .dmem_out(do0), .mem_in(mi0), .mem_out(mem_out), .grant_instr(g0));

  mem_arbiter #(.RR_MODE(1'b1)) dut1 (
    .clock(clock), .reset(reset), .imem_in(imem_in), .imem_out(io1),
    .dmem_in(dmem_in), .dmem_out(do1), .mem_in(mi1), .mem_out(mem_out), .grant_instr(g1));

  // ---------------- transaction-level reference model ----------------
  // owner: 0 = nothing in flight, 1 = instruction, 2 = data.
  typedef struct {
    int         owner;
    bit         wait_i;
    bit         wait_d;
    mem_in_type req_i;
    mem_in_type req_d;
    bit         last_was_d;
  } model_t;

  model_t      m0, m1, nm0, nm1;
  mem_in_type  e_mem0, e_mem1;
  mem_out_type e_i0, e_d0, e_i1, e_d1;
  logic        e_g0, e_g1;

  function automatic void model_step(input model_t m, input bit rr, input logic rst_n,
                                     input mem_in_type im, input mem_in_type dm,
                                     input mem_out_type mo,
                                     output mem_in_type e_mem, output mem_out_type e_i,
                                     output mem_out_type e_d, output logic e_g,
                                     output model_t nm);
    bit li, ld, want_i, want_d, d_wins;
    mem_in_type ri, rd;
    nm    = m;
    e_mem = '0;
    e_i   = '0;
    e_d   = '0;
    e_g   = (m.owner == 1);
    if (rst_n !== 1'b1) begin
      nm.owner = 0; nm.wait_i = 0; nm.wait_d = 0;
      nm.req_i = '0; nm.req_d = '0; nm.last_was_d = 0;
      e_g = 1'b0;
      return;
    end
    if (m.owner == 1) e_i = mo;
    else if (m.owner == 2) e_d = mo;
    li = (im.mem_valid === 1'b1);
    ld = (dm.mem_valid === 1'b1);
    want_i = li || m.wait_i;
    want_d = ld || m.wait_d;
    ri = li ? im : m.req_i;
    rd = ld ? dm : m.req_d;
    if (m.owner == 0 || mo.mem_ready === 1'b1) begin
      nm.owner = 0;
      if (want_i || want_d) begin
        d_wins = want_d && !(want_i && rr && m.last_was_d);
        if (d_wins) begin
          e_mem = rd; nm.owner = 2; nm.last_was_d = 1; nm.wait_d = 0;
          if (li) begin nm.wait_i = 1; nm.req_i = im; end
        end else begin
          e_mem = ri; nm.owner = 1; nm.last_was_d = 0; nm.wait_i = 0;
          if (ld) begin nm.wait_d = 1; nm.req_d = dm; end
        end
        e_mem.mem_valid = 1'b1;
      end
    end else begin
      if (li) begin nm.wait_i = 1; nm.req_i = im; end
      if (ld) begin nm.wait_d = 1; nm.req_d = dm; end
    end
  endfunction

  always @(negedge clock) begin
    model_step(m0, 1'b0, reset, imem_in, dmem_in, mem_out, e_mem0, e_i0, e_d0, e_g0, nm0);
    model_step(m1, 1'b1, reset, imem_in, dmem_in, mem_out, e_mem1, e_i1, e_d1, e_g1, nm1);
    if (mi0.mem_valid === 1'b1 && mi0.mem_addr === 32'h300) cnt300++;
  end

  always @(posedge clock) begin
    m0 = nm0;
    m1 = nm1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic smp();
    @(negedge clock); #1;
  endtask

  task automatic idle_in();
    imem_in = '0; dmem_in = '0; mem_out = '0;
  endtask

  function automatic mem_in_type req(input logic [31:0] addr, input logic instr,
                                     input logic spec, input logic [3:0] wstrb);
    mem_in_type r;
    r = '0;
    r.mem_valid = 1'b1; r.mem_instr = instr; r.mem_spec = spec;
    r.mem_addr = addr; r.mem_wstrb = wstrb;
    r.mem_wdata = instr ? 32'h0 : (addr ^ 32'hA5A5_0000);
    return r;
  endfunction

  task automatic pulse_reset();
    reset = 1'b0; idle_in(); cyc(); reset = 1'b1; cyc();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; idle_in();
    repeat (2) cyc();
    imem_in = req(32'h100, 1'b1, 1'b0, 4'h0);
    smp();
    n_checks++; if (mi0 !== '0) begin n_fail++; $display("FAIL reset_mem_in: got %h want 0", mi0); end
    n_checks++; if (io0 !== '0 || do0 !== '0) begin n_fail++; $display("FAIL reset_outs: got %h/%h want 0", io0, do0); end
    n_checks++; if (g0 !== 1'b0 || g1 !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b/%b want 0", g0, g1); end
    n_checks++; if (mi1 !== '0) begin n_fail++; $display("FAIL reset_mem_in_rr: got %h want 0", mi1); end
    cyc(); idle_in(); reset = 1'b1; cyc();
  endtask

  task automatic test_single_fetch();
    imem_in = req(32'h100, 1'b1, 1'b0, 4'h0);
    smp();
    n_checks++; if (mi0.mem_valid !== 1'b1 || mi0.mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_issue: got v=%b a=%h want v=1 a=100", mi0.mem_valid, mi0.mem_addr); end
    cyc(); imem_in = '0;
    smp();
    n_checks++; if (g0 !== 1'b1) begin n_fail++; $display("FAIL fetch_grant: got %b want 1", g0); end
    cyc(); mem_out = '{mem_rdata: 32'hDEADBEEF, mem_ready: 1'b1};
    smp();
    n_checks++; if (io0.mem_ready !== 1'b1 || io0.mem_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_resp: got %h want deadbeef1", io0); end
    n_checks++; if (do0 !== '0) begin n_fail++; $display("FAIL fetch_dmem_quiet: got %h want 0", do0); end
    cyc(); mem_out = '0;
    smp();
    n_checks++; if (g0 !== 1'b0) begin n_fail++; $display("FAIL fetch_grant_drop: got %b want 0", g0); end
    cyc();
  endtask

  task automatic test_priority();
    imem_in = req(32'h200, 1'b1, 1'b0, 4'h0);
    dmem_in = req(32'h8000, 1'b0, 1'b0, 4'hF);
    smp();
    n_checks++; if (mi0.mem_valid !== 1'b1 || mi0.mem_addr !== 32'h8000) begin n_fail++; $display("FAIL prio_first: got a=%h want 8000", mi0.mem_addr); end
    cyc(); imem_in = '0; dmem_in = '0;
    cyc(); mem_out = '{mem_rdata: 32'h11112222, mem_ready: 1'b1};
    smp();
    n_checks++; if (do0.mem_ready !== 1'b1 || io0.mem_ready !== 1'b0) begin n_fail++; $display("FAIL prio_route_d: got d=%b i=%b want d=1 i=0", do0.mem_ready, io0.mem_ready); end
    n_checks++; if (mi0.mem_valid !== 1'b1 || mi0.mem_addr !== 32'h200) begin n_fail++; $display("FAIL prio_second: got v=%b a=%h want v=1 a=200", mi0.mem_valid, mi0.mem_addr); end
    cyc(); mem_out = '0;
    cyc(); mem_out = '{mem_rdata: 32'h33334444, mem_ready: 1'b1};
    smp();
    n_checks++; if (io0.mem_ready !== 1'b1 || io0.mem_rdata !== 32'h33334444 || do0.mem_ready !== 1'b0) begin n_fail++; $display("FAIL prio_route_i: got i=%h d=%h want i=333344441", io0, do0); end
    cyc(); mem_out = '0; cyc();
  endtask

  task automatic test_spec_overwrite();
    cnt300 = 0;
    dmem_in = req(32'h500, 1'b0, 1'b0, 4'h3);
    cyc(); dmem_in = '0; imem_in = req(32'h300, 1'b1, 1'b0, 4'h0);
    cyc(); imem_in = req(32'h400, 1'b1, 1'b1, 4'h0);
    smp();
    n_checks++; if (mi0.mem_valid !== 1'b0) begin n_fail++; $display("FAIL spec_hold: got v=%b want 0", mi0.mem_valid); end
    cyc(); imem_in = '0; mem_out = '{mem_rdata: 32'h5, mem_ready: 1'b1};
    smp();
    n_checks++; if (do0.mem_ready !== 1'b1) begin n_fail++; $display("FAIL spec_d_resp: got %b want 1", do0.mem_ready); end
    n_checks++; if (mi0.mem_valid !== 1'b1 || mi0.mem_addr !== 32'h400 || mi0.mem_spec !== 1'b1) begin n_fail++; $display("FAIL spec_issue: got v=%b a=%h s=%b want v=1 a=400 s=1", mi0.mem_valid, mi0.mem_addr, mi0.mem_spec); end
    cyc(); mem_out = '0;
    cyc(); mem_out = '{mem_rdata: 32'h6, mem_ready: 1'b1};
    smp();
    n_checks++; if (io0.mem_ready !== 1'b1 || mi0.mem_valid !== 1'b0) begin n_fail++; $display("FAIL spec_drain: got r=%b v=%b want r=1 v=0", io0.mem_ready, mi0.mem_valid); end
    cyc(); mem_out = '0; cyc();
    n_checks++; if (cnt300 !== 0) begin n_fail++; $display("FAIL spec_stale_issued: got %0d want 0", cnt300); end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    imem_in = req(32'h1000, 1'b1, 1'b0, 4'h0);
    dmem_in = req(32'h2000, 1'b0, 1'b0, 4'hF);
    for (int k = 0; k < 6; k++) begin
      smp();
      n_checks++; if (mi1.mem_valid !== 1'b1 || mi1.mem_instr !== (k % 2 == 1)) begin n_fail++; $display("FAIL rr_grant_%0d: got v=%b instr=%b want v=1 instr=%0d", k, mi1.mem_valid, mi1.mem_instr, k % 2); end
      if (k > 0) begin
        n_checks++;
        if ((k % 2 == 0) ? (io1.mem_ready !== 1'b1) : (do1.mem_ready !== 1'b1)) begin
          n_fail++; $display("FAIL rr_route_%0d: got i=%b d=%b", k, io1.mem_ready, do1.mem_ready);
        end
      end
      cyc(); idle_in();
      cyc(); mem_out = '{mem_rdata: 32'(k), mem_ready: 1'b1};
      if (k % 2 == 1) imem_in = req(32'h1000 + 32'(k), 1'b1, 1'b0, 4'h0);
      else            dmem_in = req(32'h2000 + 32'(k), 1'b0, 1'b0, 4'hF);
    end
    cyc(); idle_in();
  endtask

  task automatic test_reset_midflight();
    pulse_reset();
    dmem_in = req(32'h700, 1'b0, 1'b0, 4'h1);
    cyc(); dmem_in = '0;
    cyc(); reset = 1'b0; imem_in = req(32'h900, 1'b1, 1'b0, 4'h0);
    smp();
    n_checks++; if (mi0 !== '0 || io0 !== '0 || do0 !== '0 || g0 !== 1'b0) begin n_fail++; $display("FAIL midreset_outs: got mi=%h i=%h d=%h g=%b want all 0", mi0, io0, do0, g0); end
    cyc(); reset = 1'b1; imem_in = '0; mem_out = '{mem_rdata: 32'hABCD, mem_ready: 1'b1};
    smp();
    n_checks++; if (do0 !== '0 || io0 !== '0 || mi0 !== '0) begin n_fail++; $display("FAIL stray_ready: got i=%h d=%h mi=%h want 0", io0, do0, mi0); end
    cyc(); mem_out = '0; imem_in = req(32'h904, 1'b1, 1'b0, 4'h0);
    smp();
    n_checks++; if (mi0.mem_valid !== 1'b1 || mi0.mem_addr !== 32'h904) begin n_fail++; $display("FAIL post_reset_issue: got v=%b a=%h want v=1 a=904", mi0.mem_valid, mi0.mem_addr); end
    cyc(); imem_in = '0; mem_out = '{mem_rdata: 32'h1, mem_ready: 1'b1};
    cyc(); mem_out = '0;
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    imem_in = req(32'h600, 1'b1, 1'b0, 4'h0);
    cyc(); imem_in = '0;
    cyc(); mem_out = '{mem_rdata: 32'h5555, mem_ready: 1'b1};
    imem_in = req(32'h604, 1'b1, 1'b0, 4'h0);
    smp();
    n_checks++; if (io0.mem_ready !== 1'b1 || io0.mem_rdata !== 32'h5555) begin n_fail++; $display("FAIL b2b_resp: got %h want 55551", io0); end
    n_checks++; if (mi0.mem_valid !== 1'b1 || mi0.mem_addr !== 32'h604 || mi0.mem_instr !== 1'b1 || mi0.mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL b2b_issue: got %h want v=1 a=604 instr=1 wstrb=0", mi0); end
    cyc(); idle_in();
    smp();
    n_checks++; if (g0 !== 1'b1) begin n_fail++; $display("FAIL b2b_grant: got %b want 1", g0); end
    cyc(); mem_out = '{mem_rdata: 32'h7, mem_ready: 1'b1};
    cyc(); mem_out = '0;
  endtask

  task automatic test_random();
    mem_in_type r;
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      imem_in = '0; dmem_in = '0;
      if ($urandom_range(0, 2) == 0) begin
        r = '0; r.mem_valid = 1'b1; r.mem_instr = 1'b1;
        r.mem_spec = 1'($urandom_range(0, 1)); r.mem_fence = 1'($urandom_range(0, 1));
        r.mem_addr = $urandom; imem_in = r;
      end
      if ($urandom_range(0, 2) == 0) begin
        r = '0; r.mem_valid = 1'b1; r.mem_addr = $urandom; r.mem_wdata = $urandom;
        r.mem_wstrb = 4'($urandom_range(0, 15)); dmem_in = r;
      end
      mem_out.mem_ready = ($urandom_range(0, 2) == 0);
      mem_out.mem_rdata = $urandom;
      smp();
      n_checks++; if (mi0 !== e_mem0) begin n_fail++; $display("FAIL rand_mem_in_fixed @%0d: got %h want %h", n, mi0, e_mem0); end
      n_checks++; if (io0 !== e_i0 || do0 !== e_d0) begin n_fail++; $display("FAIL rand_resp_fixed @%0d: got %h/%h want %h/%h", n, io0, do0, e_i0, e_d0); end
      n_checks++; if (g0 !== e_g0) begin n_fail++; $display("FAIL rand_grant_fixed @%0d: got %b want %b", n, g0, e_g0); end
      n_checks++; if (mi1 !== e_mem1) begin n_fail++; $display("FAIL rand_mem_in_rr @%0d: got %h want %h", n, mi1, e_mem1); end
      n_checks++; if (io1 !== e_i1 || do1 !== e_d1) begin n_fail++; $display("FAIL rand_resp_rr @%0d: got %h/%h want %h/%h", n, io1, do1, e_i1, e_d1); end
      n_checks++; if (g1 !== e_g1) begin n_fail++; $display("FAIL rand_grant_rr @%0d: got %b want %b", n, g1, e_g1); end
      cyc();
    end
    reset = 1'b1; idle_in(); cyc();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_single_fetch();
    test_priority();
    test_spec_overwrite();
    test_round_robin();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
